// File: rtl/imem_pkg.sv
// imem_pkg: shared owner tags, FSM states and constants
// for the instruction-memory arbiter.
package imem_pkg;

  localparam int unsigned DEF_MEM_WORDS = 16384;
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter: fetch/loader arbitration and response routing for the shared
// instruction memory. Define IMEM_ARB_ERR_EN to add address checks and err.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = DEF_MEM_WORDS,
  parameter int unsigned AW           = $clog2(MEM_WORDS),
  parameter int unsigned LD_BURST_MAX = 8,
  parameter logic [31:0] NOP_WORD     = IMEM_NOP_WORD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  input  logic          ld_lock,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [31:0]   ld_rdata,
  output logic          locked,
`ifdef IMEM_ARB_ERR_EN
  output logic          err,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned CW = $clog2(LD_BURST_MAX + 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   if_rdata_q, ld_rdata_q;
  logic [31:0]   sel_addr, resp;
  logic          sel_err, any_gnt, burst_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if_gnt    = 1'b0;
    ld_gnt    = 1'b0;
    burst_hit = (cnt_q == CW'(LD_BURST_MAX));
    unique case (state_q)
      ST_OPEN: begin
        // fetch only overtakes the loader once the burst budget is spent
        if (ld_req && !(if_req && burst_hit)) ld_gnt = 1'b1;
        else if_gnt = if_req;
        if (ld_lock) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        ld_gnt = ld_req;
        if (!ld_lock && owner_q != OWN_LD) state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
    if (!if_req || if_gnt || state_q == ST_LOCKED) cnt_d = '0;
    else if (ld_gnt) cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    any_gnt  = if_gnt | ld_gnt;
    sel_addr = ld_gnt ? ld_addr : if_addr;
`ifdef IMEM_ARB_ERR_EN
    sel_err  = any_gnt && ((sel_addr[1:0] != 2'b00) ||
               ({2'b00, sel_addr[31:2]} >= MEM_WORDS));
`else
    sel_err  = 1'b0;
`endif
    mem_en    = any_gnt & ~sel_err;
    mem_we    = mem_en & ld_gnt & ld_we;
    mem_addr  = mem_en ? sel_addr[AW+1:2] : '0;
    mem_wdata = mem_we ? ld_wdata : '0;
    unique case (1'b1)
      if_gnt:           owner_d = OWN_IF;
      ld_gnt && !ld_we: owner_d = OWN_LD;
      default:          owner_d = OWN_NONE;
    endcase
  end

`ifdef IMEM_ARB_ERR_EN
  logic err_q;
  assign err  = sel_err;
  assign resp = err_q ? NOP_WORD : mem_rdata;
`else
  logic unused_addr;
  assign unused_addr = ^{sel_addr[31:AW+2], sel_addr[1:0], sel_err};
  assign resp        = mem_rdata;
`endif

  assign locked    = (state_q == ST_LOCKED);
  assign if_rvalid = (owner_q == OWN_IF);
  assign ld_rvalid = (owner_q == OWN_LD);
  assign if_rdata  = if_rvalid ? resp : if_rdata_q;
  assign ld_rdata  = ld_rvalid ? resp : ld_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OPEN;
      owner_q    <= OWN_NONE;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
`ifdef IMEM_ARB_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata;
      ld_rdata_q <= ld_rdata;
`ifdef IMEM_ARB_ERR_EN
      err_q      <= sel_err;
`endif
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized scoreboard bench with a behavioural model.
// Add +define+IMEM_ARB_ERR_EN to cover the address-error variant.
module tb_imem_arbiter;

  localparam int WORDS = 16384;
  localparam int BURST = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ld_req = 1'b0;
  logic        ld_we = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_lock = 1'b0;
  logic        if_gnt, if_rvalid, ld_gnt, ld_rvalid, locked;
  logic [31:0] if_rdata, ld_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef IMEM_ARB_ERR_EN
  logic        err;
`endif

  imem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_lock(ld_lock), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .locked(locked),
`ifdef IMEM_ARB_ERR_EN
    .err(err),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [WORDS];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        if_q[$];
  exp_t        ld_q[$];
  logic [31:0] ref_img [int];
  int          n_chk = 0;
  int          n_pass = 0;
  int          m_streak = 0;
  bit          m_locked = 0;
  bit          m_ldrd_prev = 0;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'h1000_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] ref_rd(int idx);
    if (ref_img.exists(idx)) return ref_img[idx];
    return init_word(idx);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] w, hi, lo;
    w  = $urandom_range(0, 31);
    hi = ($urandom_range(0, 7) == 0) ? (32'($urandom_range(1, 3)) << 14) : 0;
    lo = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 0;
    return ((hi + w) << 2) | lo;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 0);
    chk({tag, "_ld_gnt"}, 32'(ld_gnt), 0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, "_ld_rvalid"}, 32'(ld_rvalid), 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_ld_rdata"}, ld_rdata, 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // One cycle: drive, predict from the model at the falling edge, advance.
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic lr, input logic lw,
                      input logic [31:0] la, input logic [31:0] lwd,
                      input logic lk, output logic gi, output logic gl);
    logic        pi, pl, bad;
    logic [31:0] a;
    int          idx;
    exp_t        e;
    if_req = ir; if_addr = ia;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd;
    ld_lock = lk;
    @(negedge clk);
    gi = if_gnt;
    gl = ld_gnt;
    pi = 1'b0;
    pl = 1'b0;
    if (m_locked) pl = lr;
    else if (lr && !(ir && m_streak == BURST)) pl = 1'b1;
    else pi = ir;
    a   = pl ? la : ia;
    idx = int'(a >> 2) % WORDS;
    bad = 1'b0;
`ifdef IMEM_ARB_ERR_EN
    bad = (pi || pl) && (a[1:0] != 2'b00 || (a >> 2) >= WORDS);
    chk("err", 32'(err), 32'(bad));
`endif
    chk("if_gnt", 32'(if_gnt), 32'(pi));
    chk("ld_gnt", 32'(ld_gnt), 32'(pl));
    chk("mem_en", 32'(mem_en), 32'((pi || pl) && !bad));
    chk("locked", 32'(locked), 32'(m_locked));
    if ((pi || pl) && !bad) begin
      chk("mem_addr", 32'(mem_addr), 32'(idx));
      chk("mem_we", 32'(mem_we), 32'(pl && lw));
    end
    if (pi) begin
      e.d = bad ? NOP : ref_rd(idx);
      e.due = cyc + 1;
      if_q.push_back(e);
    end
    if (pl && !lw) begin
      e.d = bad ? NOP : ref_rd(idx);
      e.due = cyc + 1;
      ld_q.push_back(e);
    end
    if (pl && lw && !bad) begin
      chk("mem_wdata", mem_wdata, lwd);
      ref_img[idx] = lwd;
    end
    if (m_locked) begin
      m_streak = 0;
      if (!lk && !m_ldrd_prev) m_locked = 0;
    end else begin
      if (!ir || pi) m_streak = 0;
      else if (pl) m_streak++;
      if (lk) m_locked = 1;
    end
    m_ldrd_prev = pl && !lw;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [31:0] last_if, last_ld;
    exp_t e;
    last_if = '0;
    last_ld = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_if_rvalid", 32'(if_rvalid), 0);
        chk("rst_ld_rvalid", 32'(ld_rvalid), 0);
        last_if = '0;
        last_ld = '0;
      end else begin
        if (if_rvalid) begin
          if (if_q.size() == 0) chk("if_spurious_rvalid", 32'(if_rvalid), 0);
          else begin
            e = if_q.pop_front();
            chk("if_rdata", if_rdata, e.d);
            chk("if_latency", 32'(cyc), 32'(e.due));
          end
        end else chk("if_rdata_hold", if_rdata, last_if);
        if (ld_rvalid) begin
          if (ld_q.size() == 0) chk("ld_spurious_rvalid", 32'(ld_rvalid), 0);
          else begin
            e = ld_q.pop_front();
            chk("ld_rdata", ld_rdata, e.d);
            chk("ld_latency", 32'(cyc), 32'(e.due));
          end
        end else chk("ld_rdata_hold", ld_rdata, last_ld);
        last_if = if_rdata;
        last_ld = ld_rdata;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic        gi, gl, ir, lr, lw, lk;
    logic [31:0] ia, la, lwd;
    int          ci, cl;
    for (int i = 0; i < WORDS; i++) ram[i] = init_word(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    step(1, 32'h10, 0, 0, 0, 0, 0, gi, gl);
    chk("single_gnt", 32'(gi), 1);
    chk("single_rvalid", 32'(if_rvalid), 1);
    chk("single_rdata", if_rdata, 32'hDEAD_BEEF);

    ci = 0;
    cl = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 32'h20, 1, 0, 32'h40, 0, 0, gi, gl);
      ci += int'(gi);
      cl += int'(gl);
      chk("no_dual_gnt", 32'(gi & gl), 0);
    end
    chk("contention_ld_grants", 32'(cl), 18);
    chk("contention_if_grants", 32'(ci), 2);

    step(1, 32'h0, 0, 0, 0, 0, 1, gi, gl);
    step(1, 32'h0, 1, 1, 32'h0, 32'h0010_0093, 1, gi, gl);
    chk("lock_if_blocked", 32'(gi), 0);
    chk("lock_ld_write", 32'(gl), 1);
    step(1, 32'h0, 0, 0, 0, 0, 0, gi, gl);
    chk("lock_still_blocked", 32'(gi), 0);
    step(1, 32'h0, 0, 0, 0, 0, 0, gi, gl);
    chk("unlock_if_gnt", 32'(gi), 1);
    chk("unlock_fetch_data", if_rdata, 32'h0010_0093);

    step(1, 32'h0, 0, 0, 0, 0, 0, gi, gl);
    step(1, 32'h4, 0, 0, 0, 0, 0, gi, gl);
    step(1, 32'h8, 0, 0, 0, 0, 0, gi, gl);

    step(1, 32'h2, 0, 0, 0, 0, 0, gi, gl);
`ifdef IMEM_ARB_ERR_EN
    chk("misaligned_nop", if_rdata, NOP);
`endif
    step(1, 32'h1_0000, 0, 0, 0, 0, 0, gi, gl);
`ifdef IMEM_ARB_ERR_EN
    chk("out_of_range_nop", if_rdata, NOP);
`endif

    step(1, 32'h10, 0, 0, 0, 0, 0, gi, gl);
    rst_n = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0;
    if_addr = '0; ld_addr = '0; ld_wdata = '0;
    if_q.delete();
    ld_q.delete();
    m_streak = 0;
    m_locked = 0;
    m_ldrd_prev = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");
    @(posedge clk);
    #1;

    ir = 0; lr = 0; lw = 0; lk = 0;
    ia = '0; la = '0; lwd = '0;
    gi = 0; gl = 0;
    for (int n = 0; n < 600; n++) begin
      if (!ir || gi) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = rand_addr();
      end
      if (!lr || gl) begin
        lr  = ($urandom_range(0, 3) != 0);
        lw  = ($urandom_range(0, 1) != 0);
        la  = rand_addr();
        lwd = $urandom();
      end
      if ($urandom_range(0, 19) == 0) lk = ~lk;
      step(ir, ia, lr, lw, la, lwd, lk, gi, gl);
    end
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 0, 0, gi, gl);
    chk("if_queue_drained", 32'(if_q.size()), 0);
    chk("ld_queue_drained", 32'(ld_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
